// File: rtl/sync_mux_pkg.sv
// rtl/sync_mux_pkg.sv - shared defaults and sizing helper for sync_mux
package sync_mux_pkg;

    localparam int DEF_ELEM_WIDTH = 8;
    localparam int DEF_NUM_ELEM   = 6;

    // Number of mux leaves after padding the element count up to a power of two.
    function automatic int pad_leaves(input int num_elem);
        return 1 << $clog2(num_elem);
    endfunction

endpackage

// File: rtl/sync_mux_dff_ar.sv
// rtl/sync_mux_dff_ar.sv - word-wide flip-flop with asynchronous active-low reset to zero
module dff_ar #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = d_i;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/sync_mux.sv
// rtl/sync_mux.sv - N-to-1 word mux with combinational and registered outputs
module sync_mux
    import sync_mux_pkg::*;
#(
    parameter int  ELEM_WIDTH = DEF_ELEM_WIDTH,
    parameter int  NUM_ELEM   = DEF_NUM_ELEM,
    localparam int SEL_WIDTH  = $clog2(NUM_ELEM)
) (
    input  logic                                 clk_i,
    input  logic                                 arst_ni,
    input  logic [SEL_WIDTH-1:0]                 s_i,
    input  logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  i_i,
    output logic [ELEM_WIDTH-1:0]                o_o,
    output logic [ELEM_WIDTH-1:0]                q_o,
    output logic                                 sel_err_o
);

    localparam int                 LEAVES     = pad_leaves(NUM_ELEM);
    localparam logic [SEL_WIDTH:0] NUM_ELEM_W = (SEL_WIDTH + 1)'(NUM_ELEM);

    if (NUM_ELEM < 2 || ELEM_WIDTH < 1) begin : g_param_check
        $fatal(1, "sync_mux: NUM_ELEM must be >= 2 and ELEM_WIDTH >= 1");
    end

    logic [LEAVES-1:0][ELEM_WIDTH-1:0] leaf;
    logic [ELEM_WIDTH-1:0]             sel_word;
    logic                              sel_err;

    // Padding leaves stay zero, so an out-of-range index reads back 0 without extra gating.
    always_comb begin
        leaf = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            leaf[k] = i_i[k];
        end
    end

    always_comb begin
        sel_word = leaf[s_i];
        sel_err  = ({1'b0, s_i} >= NUM_ELEM_W);
    end

    assign o_o       = sel_word;
    assign sel_err_o = sel_err;

    dff_ar #(
        .WIDTH (ELEM_WIDTH)
    ) u_q_reg (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .d_i     (sel_word),
        .q_o     (q_o)
    );

endmodule

// File: tb/tb_sync_mux.sv
// tb/tb_sync_mux.sv - directed self-checking bench for sync_mux
module tb_sync_mux;

    logic clk = 1'b0;
    logic arst_n;

    always #5 clk = ~clk;

    // default configuration: 6 x 8 bits
    logic [2:0]      s_a;
    logic [5:0][7:0] i_a;
    logic [7:0]      o_a, q_a;
    logic            err_a;

    // narrow configuration: 2 x 1 bit
    logic            s_b;
    logic [1:0][0:0] i_b;
    logic [0:0]      o_b, q_b;
    logic            err_b;

    // wide configuration: 8 x 32 bits
    logic [2:0]       s_c;
    logic [7:0][31:0] i_c;
    logic [31:0]      o_c, q_c;
    logic             err_c;

    int n_checks = 0;
    int n_fail   = 0;

    sync_mux #(.ELEM_WIDTH(8), .NUM_ELEM(6)) dut (
        .clk_i(clk), .arst_ni(arst_n), .s_i(s_a), .i_i(i_a),
        .o_o(o_a), .q_o(q_a), .sel_err_o(err_a)
    );

    sync_mux #(.ELEM_WIDTH(1), .NUM_ELEM(2)) dut_narrow (
        .clk_i(clk), .arst_ni(arst_n), .s_i(s_b), .i_i(i_b),
        .o_o(o_b), .q_o(q_b), .sel_err_o(err_b)
    );

    sync_mux #(.ELEM_WIDTH(32), .NUM_ELEM(8)) dut_wide (
        .clk_i(clk), .arst_ni(arst_n), .s_i(s_c), .i_i(i_c),
        .o_o(o_c), .q_o(q_c), .sel_err_o(err_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] model [6];
    logic [7:0] exp_b;
    int         sel;

    initial begin
        arst_n = 1'b0;
        s_a = 3'd0; i_a = {8'hF6, 8'hE5, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        s_b = 1'b0; i_b = '0;
        s_c = 3'd0; i_c = '0;
        #1;
        check("reset_q_initial", q_a, 8'h00);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("reset_q_hold", q_a, 8'h00);
        end

        // release reset away from the edge, then capture element 2
        s_a = 3'd2; i_a[2] = 8'hA5;
        @(negedge clk);
        arst_n = 1'b1;
        check("o_before_first_edge", o_a, 8'hA5);
        check("q_before_first_edge", q_a, 8'h00);
        tick();
        check("q_first_capture", q_a, 8'hA5);

        // exhaustive in-range sweep
        i_a = {8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        for (int s = 0; s < 6; s++) begin
            s_a = s[2:0];
            #1;
            check("sweep_o", o_a, 32'(s + 1));
            check("sweep_err", err_a, 1'b0);
        end

        // out-of-range selects
        s_a = 3'd6; #1;
        check("oor6_o", o_a, 8'h00);
        check("oor6_err", err_a, 1'b1);
        s_a = 3'd7; #1;
        check("oor7_o", o_a, 8'h00);
        check("oor7_err", err_a, 1'b1);
        tick();
        check("oor_q", q_a, 8'h00);

        // random regression against a word-array model
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 6; k++) begin
                model[k] = 8'($urandom_range(0, 255));
                i_a[k]   = model[k];
            end
            for (int j = 0; j < 6; j++) begin
                sel = $urandom_range(0, 5);
                s_a = sel[2:0];
                #1;
                check("MUX selection", o_a, model[sel]);
            end
        end

        // one-bit, two-element boundary
        for (int v = 0; v < 4; v++) begin
            i_b[0] = v[0];
            i_b[1] = v[1];
            s_b = 1'b0; #1;
            exp_b = {7'd0, v[0]};
            check("narrow_s0", o_b, exp_b);
            s_b = 1'b1; #1;
            exp_b = {7'd0, v[1]};
            check("narrow_s1", o_b, exp_b);
            check("narrow_err", err_b, 1'b0);
        end

        // 32-bit, eight-element boundary
        i_c = {32'hFFFF_FFFF, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444,
               32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        for (int s = 0; s < 8; s++) begin
            s_c = s[2:0];
            #1;
            check("wide_o", o_c, (s == 7) ? 32'hFFFF_FFFF : {8{s[3:0]}});
            check("wide_err", err_c, 1'b0);
        end
        tick();
        check("wide_q", q_c, 32'hFFFF_FFFF);

        // mid-operation asynchronous reset
        i_a = {8'h06, 8'h05, 8'h04, 8'h03, 8'h5A, 8'h01};
        s_a = 3'd1;
        tick();
        check("mid_q_before", q_a, 8'h5A);
        #2;
        arst_n = 1'b0;
        #1;
        check("mid_q_async", q_a, 8'h00);
        check("mid_o_kept", o_a, 8'h5A);
        s_a = 3'd4; #1;
        check("mid_o_tracks", o_a, 8'h05);
        tick();
        check("mid_q_held", q_a, 8'h00);
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        check("mid_q_recapture", q_a, 8'h05);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_mux.md
# sync_mux

Parameterised N-to-1 word multiplexer: selects one of NUM_ELEM packed input words by a binary index. Provides a zero-latency combinational output plus a one-cycle registered copy and an out-of-range select flag. Generic datapath-steering leaf used wherever a design picks one lane from a packed bus.

## Interface

- Clocking: one clock; reset is asynchronous and active-low (clk_i, arst_ni).

Parameters:
- ELEM_WIDTH, default 8: width of each element in bits; legal range ≥ 1.
- NUM_ELEM, default 6: number of selectable elements; legal range ≥ 2.

Ports:
- clk_i, input, 1: clock; rising-edge active.
- arst_ni, input, 1: asynchronous active-low reset.
- s_i, input, $clog2(NUM_ELEM): binary select index.
- i_i, input, NUM_ELEM × ELEM_WIDTH packed ([NUM_ELEM-1:0][ELEM_WIDTH-1:0]): element k at i_i[k].
- o_o, output, ELEM_WIDTH: combinational selected element.
- q_o, output, ELEM_WIDTH: registered o_o.
- sel_err_o, output, 1: combinational flag; high when s_i ≥ NUM_ELEM.

## Operation

- o_o = i_i[s_i] when s_i < NUM_ELEM.
- Out-of-range select (s_i ≥ NUM_ELEM, possible when NUM_ELEM is not a power of two): o_o = 0 and sel_err_o = 1.
- sel_err_o = 0 for every in-range s_i.
- o_o is purely combinational:
  - no dependence on clk_i or arst_ni;
  - no latches;
  - X-free whenever s_i and i_i are known.
- q_o captures o_o on each rising clk_i edge. Out-of-range selects are captured as 0.
- Every element is reachable, including index 0 and index NUM_ELEM-1.
- All ELEM_WIDTH bits pass unmodified: no truncation and no sign handling.
- Parameter check at elaboration: NUM_ELEM < 2 or ELEM_WIDTH < 1 is a fatal error.

## Timing

- o_o and sel_err_o: zero-cycle latency. They settle within the same delta/timestep as any change on s_i or i_i.
- q_o: one-cycle latency. q_o after edge n equals o_o sampled just before edge n.
- Reset:
  - arst_ni low forces q_o = 0 immediately, asynchronously, regardless of clk_i.
  - q_o holds 0 while arst_ni is low.
  - First capture happens at the first rising edge after arst_ni deasserts.
- Reset has no effect on o_o or sel_err_o.
- Simultaneous change of s_i and i_i: o_o reflects the new pair. There is no ordering hazard.
- No handshake. The block never stalls.

## Structure

- No shared package required. SEL_WIDTH = $clog2(NUM_ELEM) is a localparam inside the block.
- One natural sub-module, `dff_ar`: an ELEM_WIDTH-wide flip-flop with asynchronous active-low reset to 0, used for q_o.
- Selection logic:
  - Either an indexed read or a generate-built log2-depth binary tree of 2:1 stages.
  - Leaves beyond NUM_ELEM are tied to 0.
  - Both implementations must give identical results.

## Test plan

- Reset: hold arst_ni=0 while toggling clk_i with i_i nonzero → q_o=0 throughout. Release reset, s_i=2, i_i[2]=8'hA5 → q_o=8'hA5 after the next edge.
- Exhaustive in-range select, default params: i_i = {8'h06,8'h05,8'h04,8'h03,8'h02,8'h01} (element 0 = 8'h01), s_i swept 0..5 → o_o = s_i+1 each step, sel_err_o=0.
- Out-of-range: s_i=6 and s_i=7 → o_o=8'h00, sel_err_o=1. Next clock edge → q_o=8'h00.
- Random regression:
  - 10 rounds; each round loads NUM_ELEM random words in 0..255, then applies 6 random in-range selects.
  - Check o_o == i_i[s_i] after each select settles.
  - All 60 checks pass → "MUX selection" PASS.
- Boundary widths: NUM_ELEM=2, ELEM_WIDTH=1, all four combinations of i_i with s_i=0/1 → correct bit. Then NUM_ELEM=8, ELEM_WIDTH=32, all-ones in element 7 → o_o=32'hFFFFFFFF, sel_err_o never asserted.
- Mid-operation reset: q_o=8'h5A, assert arst_ni between clock edges → q_o=0 immediately. o_o is unchanged (still tracks i_i[s_i]).
